// File: rtl/universal_shift_reg_if.sv
// Control, data and status bundle for universal_shift_reg.
// The master drives the operation controls and the slave returns the register state.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CNT_W-1:0] cnt;
    logic             done;

    modport master (
        output en, mode, d, sin_lsb, sin_msb,
        input  q, sout, cnt, done
    );

    modport slave (
        input  en, mode, d, sin_lsb, sin_msb,
        output q, sout, cnt, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left/right (serial-in or rotate) and parallel load,
// with a saturating shift counter and a one-cycle done pulse when the count reaches WIDTH.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               ROTATE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    universal_shift_reg_if.slave  bus
);
    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shl_in, shr_in, is_shift;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        q_d      = q_q;
        sout_d   = sout_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        shl_in   = ROTATE ? q_q[WIDTH-1] : bus.sin_lsb;
        shr_in   = ROTATE ? q_q[0]       : bus.sin_msb;

        if (bus.en) begin
            unique case (mode)
                MODE_HOLD: ;
                MODE_SHL: begin
                    // Concatenate then truncate so WIDTH=1 needs no special slice.
                    q_d      = WIDTH'({q_q, shl_in});
                    sout_d   = q_q[WIDTH-1];
                    is_shift = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = WIDTH'({shr_in, q_q} >> 1);
                    sout_d   = q_q[0];
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = bus.d;
                    cnt_d = '0;
                end
            endcase
        end

        // Only the shift that lands on CNT_MAX pulses done; saturated shifts leave it low.
        if (is_shift && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            q_q    <= RESET_VAL;
            sout_q <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.cnt  = cnt_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: four instances (8-bit shift, 8-bit rotate, 1-bit, 16-bit)
// share controls and are compared each cycle against an arithmetic reference model.
module tb_universal_shift_reg;
    localparam int N = 4;

    typedef struct {
        logic [63:0] q;
        logic        sout;
        int          cnt;
        logic        done;
    } model_t;

    int          width_of [N] = '{8, 8, 1, 16};
    bit          rot_of   [N] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] rv_of    [N] = '{64'hA5, 64'hA5, 64'h1, 64'hA5A5};

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic        sl, sr;
    logic [63:0] dd [N];

    model_t      m [N];
    logic [63:0] obs_q    [N];
    logic        obs_sout [N];
    logic [63:0] obs_cnt  [N];
    logic        obs_done [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    universal_shift_reg_if #(.WIDTH(8))  if8  ();
    universal_shift_reg_if #(.WIDTH(8))  if8r ();
    universal_shift_reg_if #(.WIDTH(1))  if1  ();
    universal_shift_reg_if #(.WIDTH(16)) if16 ();

    universal_shift_reg #(.WIDTH(8),  .RESET_VAL(8'hA5),    .ROTATE(1'b0)) u8  (.clk(clk), .reset(reset), .bus(if8));
    universal_shift_reg #(.WIDTH(8),  .RESET_VAL(8'hA5),    .ROTATE(1'b1)) u8r (.clk(clk), .reset(reset), .bus(if8r));
    universal_shift_reg #(.WIDTH(1),  .RESET_VAL(1'b1),     .ROTATE(1'b0)) u1  (.clk(clk), .reset(reset), .bus(if1));
    universal_shift_reg #(.WIDTH(16), .RESET_VAL(16'hA5A5), .ROTATE(1'b0)) u16 (.clk(clk), .reset(reset), .bus(if16));

    assign if8.en  = en;  assign if8.mode  = mode; assign if8.sin_lsb  = sl; assign if8.sin_msb  = sr;
    assign if8r.en = en;  assign if8r.mode = mode; assign if8r.sin_lsb = sl; assign if8r.sin_msb = sr;
    assign if1.en  = en;  assign if1.mode  = mode; assign if1.sin_lsb  = sl; assign if1.sin_msb  = sr;
    assign if16.en = en;  assign if16.mode = mode; assign if16.sin_lsb = sl; assign if16.sin_msb = sr;
    assign if8.d  = dd[0][7:0];
    assign if8r.d = dd[1][7:0];
    assign if1.d  = dd[2][0:0];
    assign if16.d = dd[3][15:0];

    always_comb begin
        obs_q[0] = 64'(if8.q);  obs_sout[0] = if8.sout;  obs_cnt[0] = 64'(if8.cnt);  obs_done[0] = if8.done;
        obs_q[1] = 64'(if8r.q); obs_sout[1] = if8r.sout; obs_cnt[1] = 64'(if8r.cnt); obs_done[1] = if8r.done;
        obs_q[2] = 64'(if1.q);  obs_sout[2] = if1.sout;  obs_cnt[2] = 64'(if1.cnt);  obs_done[2] = if1.done;
        obs_q[3] = 64'(if16.q); obs_sout[3] = if16.sout; obs_cnt[3] = 64'(if16.cnt); obs_done[3] = if16.done;
    end

    // Reference: the register is a number modulo 2^w; shifts are multiply/divide by two.
    function automatic model_t mstep(model_t s, int w, bit rot, logic e, logic [1:0] md,
                                     logic [63:0] din, logic inl, logic inr);
        model_t      r = s;
        logic [63:0] lim  = 64'd1 << w;
        logic [63:0] half = lim / 2;
        logic [63:0] top  = (s.q / half) % 2;
        logic [63:0] bot  = s.q % 2;
        logic [63:0] inb;
        bit          shifted = 1'b0;
        r.done = 1'b0;
        if (e) begin
            if (md == 2'b11) begin
                r.q   = din % lim;
                r.cnt = 0;
            end else if (md == 2'b01) begin
                inb     = rot ? top : 64'(inl);
                r.q     = (s.q * 2 + inb) % lim;
                r.sout  = top[0];
                shifted = 1'b1;
            end else if (md == 2'b10) begin
                inb     = rot ? bot : 64'(inr);
                r.q     = s.q / 2 + inb * half;
                r.sout  = bot[0];
                shifted = 1'b1;
            end
        end
        if (shifted) begin
            r.cnt  = (s.cnt < w) ? s.cnt + 1 : w;
            r.done = (s.cnt < w) && (r.cnt == w);
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_u%0d_q", tag, i),    obs_q[i],           m[i].q);
            check($sformatf("%s_u%0d_sout", tag, i), 64'(obs_sout[i]),   64'(m[i].sout));
            check($sformatf("%s_u%0d_cnt", tag, i),  obs_cnt[i],         64'(m[i].cnt));
            check($sformatf("%s_u%0d_done", tag, i), 64'(obs_done[i]),   64'(m[i].done));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m[i].q    = rv_of[i];
            m[i].sout = 1'b0;
            m[i].cnt  = 0;
            m[i].done = 1'b0;
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        if (!reset)
            for (int i = 0; i < N; i++)
                m[i] = mstep(m[i], width_of[i], rot_of[i], en, mode, dd[i], sl, sr);
        #1 check_all(tag);
    endtask

    // Called 1 ns after an edge: asserts reset mid-cycle and checks before the next edge.
    task automatic async_reset(string tag);
        #4 reset = 1'b1;
        model_reset();
        #1 check_all(tag);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b00; sl = 1'b0; sr = 1'b0;
        for (int i = 0; i < N; i++) dd[i] = '0;
        model_reset();
        @(negedge clk);
        check_all("por");
        check("por_q8", obs_q[0], 64'hA5);
        reset = 1'b0;

        // Async reset with a load pending: reset wins immediately and across edges.
        en = 1'b1; mode = 2'b11;
        step("pre");
        async_reset("arst");
        check("arst_q", obs_q[0], 64'hA5);
        check("arst_cnt", obs_cnt[0], 64'd0);
        check("arst_sout", 64'(obs_sout[0]), 64'd0);
        step("arst_hold1");
        step("arst_hold2");
        check("arst_hold_q", obs_q[0], 64'hA5);
        @(negedge clk) reset = 1'b0;

        // Load then shift left with sin_lsb=1 across all widths.
        mode = 2'b11; dd[0] = 64'h3C; dd[1] = 64'h3C; dd[2] = 64'h1; dd[3] = 64'h3C3C;
        step("load");
        mode = 2'b01; sl = 1'b1;
        step("shl1");
        check("shl1_q", obs_q[0], 64'h79);
        check("shl1_sout", 64'(obs_sout[0]), 64'd0);
        check("w1_done", 64'(obs_done[2]), 64'd1);
        for (int k = 2; k <= 7; k++) begin
            step("shl");
            check("shl_nodone", 64'(obs_done[0]), 64'd0);
        end
        step("shl8");
        check("shl8_q", obs_q[0], 64'hFF);
        check("shl8_sout", 64'(obs_sout[0]), 64'd0);
        check("shl8_cnt", obs_cnt[0], 64'd8);
        check("shl8_done", 64'(obs_done[0]), 64'd1);
        step("shl9");
        check("shl9_cnt", obs_cnt[0], 64'd8);
        check("shl9_done", 64'(obs_done[0]), 64'd0);
        for (int k = 10; k <= 16; k++) step("shl16");
        check("w16_cnt", obs_cnt[3], 64'd16);
        check("w16_done", 64'(obs_done[3]), 64'd1);
        step("shl17");
        check("w16_sat_done", 64'(obs_done[3]), 64'd0);

        // Rotate instance: right then left.
        mode = 2'b11; dd[1] = 64'h81;
        step("rload");
        mode = 2'b10;
        step("rshr");
        check("rot_shr_q", obs_q[1], 64'hC0);
        check("rot_shr_sout", 64'(obs_sout[1]), 64'd1);
        mode = 2'b01;
        step("rshl");
        check("rot_shl_q", obs_q[1], 64'h81);
        check("rot_shl_sout", 64'(obs_sout[1]), 64'd1);

        // Enable gating.
        mode = 2'b11; dd[0] = 64'h3C;
        step("gload");
        en = 1'b0; dd[0] = 64'h00;
        for (int k = 0; k < 6; k++) begin
            mode = (k < 3) ? 2'b11 : 2'b01;
            step("gate");
            check("gate_q", obs_q[0], 64'h3C);
            check("gate_cnt", obs_cnt[0], 64'd0);
            check("gate_done", 64'(obs_done[0]), 64'd0);
        end

        // Reset mid-sequence aborts counting without a done pulse.
        en = 1'b1; mode = 2'b11; dd[0] = 64'h00;
        step("mload");
        mode = 2'b01; sl = 1'b1;
        for (int k = 0; k < 5; k++) step("mshift");
        async_reset("mrst");
        step("mrst_hold");
        @(negedge clk) reset = 1'b0;
        sl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("mpost");
            check("mpost_done", 64'(obs_done[0]), 64'd0);
        end
        check("mpost_q", obs_q[0], 64'h28);
        check("mpost_cnt", obs_cnt[0], 64'd3);

        // Random traffic against the model, with occasional asynchronous resets.
        for (int it = 0; it < 400; it++) begin
            en   = ($urandom_range(9) != 0);
            mode = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
            sl   = 1'($urandom_range(1));
            sr   = 1'($urandom_range(1));
            for (int i = 0; i < N; i++) dd[i] = {$urandom, $urandom};
            step("rnd");
            if ($urandom_range(59) == 0) begin
                async_reset("rnd_rst");
                @(negedge clk) reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
